// File: rtl/aes_pkg.sv
// Shared types and constant tables for the AES-256 inverse key schedule.
// Holds the forward S-box, the round constants and the FSM state encoding.
package aes_pkg;

    localparam int NK = 8;
    localparam int NR = 14;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_HI,
        EMIT_LO,
        CALC
    } inv_ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is never selected; the schedule only uses Rcon[1..7].
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes256_inv_key_schedule.sv
// Reverse AES-256 key schedule: regenerates rk14..rk0 from w52..w59, one word per cycle.
// Optional macro INV_KS_KEY_OUT_EN adds cipher_key_o/key_valid_o carrying the recovered key.
module aes256_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [255:0] last_key_i,
    output logic [127:0] rk_data_o,
    output logic [3:0]   rk_idx_o,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic         busy_o,
    output logic         done_o
`ifdef INV_KS_KEY_OUT_EN
    ,
    output logic [255:0] cipher_key_o,
    output logic         key_valid_o
`endif
);

    inv_ks_state_t state_q, state_d;
    word_t         win_q [NK];
    word_t         win_d [NK];
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [127:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic          hs;
    logic [5:0]    j;
    logic          rotSel;
    logic          subSel;
    word_t         subIn;
    word_t         subOut;
    word_t         tWord;
    word_t         newWord;

    assign hs = valid_q & rk_ready_i;

    // During CALC for key r, the word being undone is w[j] with j = 4r+11-cnt.
    assign j       = {idx_q, 2'b00} + 6'd11 - {4'b0000, cnt_q};
    assign rotSel  = (j[2:0] == 3'd0);
    assign subSel  = (j[2:0] == 3'd4);
    assign subIn   = rotSel ? {win_q[6][23:0], win_q[6][31:24]} : win_q[6];
    assign tWord   = rotSel ? (subOut ^ {RCON[j[5:3]], 24'h000000})
                   : subSel ? subOut : win_q[6];
    assign newWord = win_q[7] ^ tWord;

    aes_sub_word u_sub_word (
        .word_i (subIn),
        .word_o (subOut)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !done_q) begin
                    state_d = EMIT_HI;
                    for (int k = 0; k < NK; k++) begin
                        win_d[k] = last_key_i[(NK-1-k)*32 +: 32];
                    end
                    data_d  = last_key_i[127:0];
                    idx_d   = 4'(NR);
                    valid_d = 1'b1;
                end
            end
            EMIT_HI: begin
                if (hs) begin
                    state_d = EMIT_LO;
                    data_d  = {win_q[0], win_q[1], win_q[2], win_q[3]};
                    idx_d   = idx_q - 4'd1;
                end
            end
            EMIT_LO: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 2'd0;
                        idx_d   = idx_q - 4'd1;
                    end
                end
            end
            CALC: begin
                win_d[0] = newWord;
                for (int k = 1; k < NK; k++) begin
                    win_d[k] = win_q[k-1];
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = EMIT_LO;
                    valid_d = 1'b1;
                    data_d  = {newWord, win_q[0], win_q[1], win_q[2]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= '0;
            end
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign rk_data_o  = data_q;
    assign rk_idx_o   = idx_q;
    assign rk_valid_o = valid_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

`ifdef INV_KS_KEY_OUT_EN
    logic [255:0] cipherKey_q;

    // On the rk0 handshake the window holds w0..w7, i.e. the original key.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cipherKey_q <= '0;
        end else if (done_d) begin
            cipherKey_q <= {win_q[0], win_q[1], win_q[2], win_q[3],
                            win_q[4], win_q[5], win_q[6], win_q[7]};
        end
    end

    assign cipher_key_o = cipherKey_q;
    assign key_valid_o  = done_q;
`endif

endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// Scoreboard bench for aes256_inv_key_schedule: a forward AES-256 expansion (S-box from GF(2^8)
// arithmetic) predicts every round key; a negedge monitor pops and compares on each handshake.
module tb_aes256_inv_key_schedule;

    localparam logic [255:0] FIPS_KEY  =
        256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] FIPS_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } expKey_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] lastKey;
    logic [127:0] rkData;
    logic [3:0]   rkIdx;
    logic         rkValid;
    logic         rkReady;
    logic         busy;
    logic         done;

    expKey_t      expQ [$];
    logic [31:0]  wRef [60];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           startCycle = 0;
    int           lastHsCycle = 0;
    int           lastHsIdx = 15;
    int           doneCount = 0;
    int           readyMode = 0;
    logic         prevValid = 1'b0;
    logic         prevReady = 1'b0;
    logic [127:0] prevData = '0;
    logic [3:0]   prevIdx = '0;

    aes256_inv_key_schedule dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .last_key_i (lastKey),
        .rk_data_o  (rkData),
        .rk_idx_o   (rkIdx),
        .rk_valid_o (rkValid),
        .rk_ready_i (rkReady),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sboxRef(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int k = 1; k < 8; k++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        s = inv;
        for (int n = 1; n < 5; n++) begin
            s = s ^ ((inv << n) | (inv >> (8 - n)));
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWordRef(input logic [31:0] w);
        return {sboxRef(w[31:24]), sboxRef(w[23:16]), sboxRef(w[15:8]), sboxRef(w[7:0])};
    endfunction

    task automatic expandKey(input logic [255:0] key);
        logic [31:0] temp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 8; i++) wRef[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = wRef[i-1];
            if (i % 8 == 0) begin
                temp = subWordRef({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gfMul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                temp = subWordRef(temp);
            end
            wRef[i] = wRef[i-8] ^ temp;
        end
    endtask

    // Push all 15 expected keys, then pulse start for one cycle.
    task automatic applyStimulus(input logic [255:0] key, input bit useFips);
        logic [127:0] d;
        expandKey(key);
        lastHsIdx = 15;
        for (int r = 14; r >= 0; r--) begin
            d = {wRef[4*r], wRef[4*r+1], wRef[4*r+2], wRef[4*r+3]};
            if (r == 1) d = key[127:0];
            if (r == 0) d = key[255:128];
            if (useFips && r == 14) d = FIPS_RK14;
            expQ.push_back('{idx: 4'(r), data: d});
        end
        @(posedge clk);
        #1;
        lastKey = {wRef[52], wRef[53], wRef[54], wRef[55], wRef[56], wRef[57], wRef[58], wRef[59]};
        start = 1'b1;
        startCycle = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitForDone(input int maxCycles);
        int base = doneCount;
        int n = 0;
        while (doneCount == base && n < maxCycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("doneSeen", 128'(doneCount != base), 128'd1);
        checkOutput("queueDrained", 128'(expQ.size()), 128'd0);
    endtask

    task automatic waitForKey(input logic [3:0] idx, input bit needHs, input int maxCycles);
        int n = 0;
        while (!(rkValid && rkIdx == idx && (!needHs || rkReady)) && n < maxCycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("keyReached", 128'(n < maxCycles), 128'd1);
    endtask

    // Consumer-side ready generator: 0 = always ready, 2 = never ready, else random with long lows.
    initial begin
        int lowRun;
        lowRun = 0;
        rkReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 0) begin
                rkReady = 1'b1;
            end else if (readyMode == 2) begin
                rkReady = 1'b0;
            end else if (lowRun > 0) begin
                rkReady = 1'b0;
                lowRun--;
            end else if ($urandom_range(0, 24) == 0) begin
                rkReady = 1'b0;
                lowRun = 9;
            end else begin
                rkReady = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: stall stability, presentation latency, handshake scoreboard and done timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid <= 1'b0;
            prevReady <= 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("stallValid", 128'(rkValid), 128'd1);
                checkOutput("stallData", rkData, prevData);
                checkOutput("stallIdx", 128'(rkIdx), 128'(prevIdx));
            end
            if (rkValid && (!prevValid || prevReady)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 128'(rkValid), 128'd0);
                end else begin
                    checkOutput("busyWhileValid", 128'(busy), 128'd1);
                    if (expQ[0].idx == 4'd14)
                        checkOutput("latencyRk14", 128'(cyc - startCycle), 128'd1);
                    else if (expQ[0].idx == 4'd13)
                        checkOutput("latencyRk13", 128'(cyc - lastHsCycle), 128'd1);
                    else
                        checkOutput("latencyCalc", 128'(cyc - lastHsCycle), 128'd5);
                end
            end
            if (rkValid && rkReady && expQ.size() != 0) begin
                checkOutput($sformatf("rkIdx%0d", expQ[0].idx), 128'(rkIdx), 128'(expQ[0].idx));
                checkOutput($sformatf("rkData%0d", expQ[0].idx), rkData, expQ[0].data);
                lastHsCycle <= cyc;
                lastHsIdx <= int'(expQ[0].idx);
                void'(expQ.pop_front());
            end
            if (done) begin
                checkOutput("doneAfterRk0", 128'(cyc - lastHsCycle), 128'd1);
                checkOutput("doneLastIdx", 128'(lastHsIdx), 128'd0);
                checkOutput("doneValidLow", 128'(rkValid), 128'd0);
                checkOutput("doneBusyLow", 128'(busy), 128'd0);
                doneCount <= doneCount + 1;
            end
            prevValid <= rkValid;
            prevReady <= rkReady;
            prevData  <= rkData;
            prevIdx   <= rkIdx;
        end
    end

    initial begin
        int baseDone;
        rst_n = 1'b0;
        start = 1'b0;
        lastKey = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetValid", 128'(rkValid), 128'd0);
        checkOutput("resetBusy", 128'(busy), 128'd0);
        checkOutput("resetDone", 128'(done), 128'd0);
        checkOutput("resetData", rkData, 128'd0);
        checkOutput("resetIdx", 128'(rkIdx), 128'd0);
        rst_n = 1'b1;

        $display("[TB] FIPS vector, always ready");
        readyMode = 0;
        applyStimulus(FIPS_KEY, 1'b1);
        waitForDone(2000);

        $display("[TB] FIPS vector, random ready with long stalls");
        readyMode = 1;
        applyStimulus(FIPS_KEY, 1'b1);
        waitForDone(4000);

        $display("[TB] start during rk9 is ignored");
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        waitForKey(4'd9, 1'b0, 4000);
        @(posedge clk);
        #1;
        lastKey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitForDone(4000);

        $display("[TB] reset during CALC for rk6");
        readyMode = 0;
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        begin
            int n = 0;
            while (lastHsIdx != 7 && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            checkOutput("reachedRk7", 128'(lastHsIdx), 128'd7);
        end
        baseDone = doneCount;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", 128'(rkValid), 128'd0);
        checkOutput("midResetBusy", 128'(busy), 128'd0);
        checkOutput("midResetDone", 128'(done), 128'd0);
        checkOutput("midResetIdx", 128'(rkIdx), 128'd0);
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("noDoneOnReset", 128'(doneCount), 128'(baseDone));
        applyStimulus(256'h0, 1'b0);
        waitForDone(2000);

        $display("[TB] back-to-back start on the cycle after done");
        readyMode = 1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        waitForDone(4000);
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        waitForDone(4000);

        $display("[TB] start coincident with done is ignored");
        readyMode = 0;
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        waitForKey(4'd0, 1'b1, 2000);
        @(posedge clk);
        #1;
        lastKey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("ignoredStartValid", 128'(rkValid), 128'd0);
        checkOutput("ignoredStartBusy", 128'(busy), 128'd0);
        checkOutput("queueAfterIgnore", 128'(expQ.size()), 128'd0);

        $display("[TB] consumer never ready");
        readyMode = 2;
        applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (40) @(negedge clk);
        #1;
        checkOutput("stallForeverValid", 128'(rkValid), 128'd1);
        checkOutput("stallForeverIdx", 128'(rkIdx), 128'd14);
        checkOutput("stallForeverBusy", 128'(busy), 128'd1);
        readyMode = 1;
        waitForDone(4000);

        $display("[TB] random keys, random ready");
        for (int t = 0; t < 3; t++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
            waitForDone(4000);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
